brg_xcel_mem_responder: RTL and testbench

//  Memory-side responder for a BRG accelerator's master port. Accepts load/store requests
//  (type, byte addr, data, byte mask, load_id opaque) on a valid/ready handshake, serves them

---
 rtl/brg_xcel_mem_pkg.sv | 33 +++
 rtl/brg_xcel_mem_resp_pipe.sv | 47 ++++
 rtl/brg_xcel_mem_responder.sv | 150 +++++++++++++++
 tb/tb_brg_xcel_mem_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/brg_xcel_mem_pkg.sv
// Package: brg_xcel_mem_pkg
// Shared request/response types and encodings for the BRG accelerator
// memory responder.
//  mem_req_s  : {we, addr, data, mask, load_id} as presented on req_*_i
//  mem_resp_s : {we, data, load_id} as returned on ret_*_o
// The struct field widths follow the responder's default port widths.
// Width parameters on brg_xcel_mem_responder must not be overridden away
// from these values.
package brg_xcel_mem_pkg;

   localparam int unsigned mem_data_width_lp    = 32;
   localparam int unsigned mem_addr_width_lp    = 32;
   localparam int unsigned mem_load_id_width_lp = 11;
   localparam int unsigned mem_mask_width_lp    = mem_data_width_lp / 8;

   localparam logic e_mem_load  = 1'b0;
   localparam logic e_mem_store = 1'b1;

   typedef struct packed {
      logic                            we;
      logic [mem_addr_width_lp-1:0]    addr;
      logic [mem_data_width_lp-1:0]    data;
      logic [mem_mask_width_lp-1:0]    mask;
      logic [mem_load_id_width_lp-1:0] load_id;
   } mem_req_s;

   typedef struct packed {
      logic                            we;
      logic [mem_data_width_lp-1:0]    data;
      logic [mem_load_id_width_lp-1:0] load_id;
   } mem_resp_s;

endpackage

// File: rtl/brg_xcel_mem_resp_pipe.sv
// Module: brg_xcel_mem_resp_pipe
// Fixed-latency response delay line: a latency_p-deep shift register of
// valid + mem_resp_s. Anything entering on v_i/data_i leaves on
// v_o/data_o exactly latency_p clocks later.
// Ports:
//  clk_i      in   clock
//  reset_n_i  in   asynchronous reset, active-low (clears valids and data)
//  v_i        in   response valid entering the pipe
//  data_i     in   response payload entering the pipe
//  v_o        out  response valid leaving the pipe
//  data_o     out  response payload leaving the pipe
module brg_xcel_mem_resp_pipe
   import brg_xcel_mem_pkg::*;
#(
   parameter int unsigned latency_p = 2
)(
   input  logic      clk_i,
   input  logic      reset_n_i,
   input  logic      v_i,
   input  mem_resp_s data_i,
   output logic      v_o,
   output mem_resp_s data_o
);

   logic [latency_p-1:0] v_r;
   mem_resp_s            data_r [latency_p];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_r <= '0;
         for (int unsigned i = 0; i < latency_p; i++) begin
            data_r[i] <= '0;
         end
      end else begin
         v_r[0]    <= v_i;
         data_r[0] <= data_i;
         for (int unsigned i = 1; i < latency_p; i++) begin
            v_r[i]    <= v_r[i-1];
            data_r[i] <= data_r[i-1];
         end
      end
   end

   assign v_o    = v_r[latency_p-1];
   assign data_o = data_r[latency_p-1];

endmodule

// File: rtl/brg_xcel_mem_responder.sv
// Module: brg_xcel_mem_responder
// Memory-side responder for a BRG accelerator master port. Serves
// load/store requests from a local word-addressed SRAM model and returns
// one response per request exactly latency_p cycles after accept, in order.
// Optional feature macro: BRG_XCEL_MEM_RESPONDER_STALL_EN
//  defined   : a 16-bit LFSR randomly withholds req_ready_o
//  undefined : req_ready_o depends only on free credits
// Ports:
//  clk_i, reset_n_i        clock, asynchronous active-low reset
//  req_v_i / req_ready_o   request handshake
//  req_we_i                1 = store, 0 = load
//  req_addr_i              byte address (low 2 bits ignored)
//  req_data_i, req_mask_i  store data and byte enables
//  req_load_id_i           opaque tag echoed on the response
//  ret_v_o                 one-cycle response valid (consumer always ready)
//  ret_we_o                1 = store acknowledge, 0 = load data
//  ret_data_o              load data (0 for stores and out-of-range loads)
//  ret_load_id_o           echoed tag
//  out_credits_o           max_out_p minus requests in flight
//  err_o                   sticky out-of-range flag
module brg_xcel_mem_responder
   import brg_xcel_mem_pkg::*;
#(
   parameter int unsigned data_width_p    = mem_data_width_lp,
   parameter int unsigned addr_width_p    = mem_addr_width_lp,
   parameter int unsigned load_id_width_p = mem_load_id_width_lp,
   parameter int unsigned mem_els_p       = 1024,
   parameter int unsigned latency_p       = 2,
   parameter int unsigned max_out_p       = 4
)(
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         req_v_i,
   output logic                         req_ready_o,
   input  logic                         req_we_i,
   input  logic [addr_width_p-1:0]      req_addr_i,
   input  logic [data_width_p-1:0]      req_data_i,
   input  logic [data_width_p/8-1:0]    req_mask_i,
   input  logic [load_id_width_p-1:0]   req_load_id_i,
   output logic                         ret_v_o,
   output logic                         ret_we_o,
   output logic [data_width_p-1:0]      ret_data_o,
   output logic [load_id_width_p-1:0]   ret_load_id_o,
   output logic [$clog2(max_out_p+1)-1:0] out_credits_o,
   output logic                         err_o
);

   localparam int unsigned idx_w_lp  = $clog2(mem_els_p);
   localparam int unsigned cnt_w_lp  = $clog2(max_out_p + 1);
   localparam int unsigned mask_w_lp = data_width_p / 8;
   localparam logic [cnt_w_lp-1:0] max_out_lp = cnt_w_lp'(max_out_p);

   mem_req_s              req;
   mem_resp_s             resp_in;
   mem_resp_s             resp_out;
   logic [data_width_p-1:0] mem_r [mem_els_p];
   logic [idx_w_lp-1:0]   idx;
   logic                  in_range;
   logic                  accept;
   logic                  stall;
   logic [cnt_w_lp-1:0]   inflight_r;
   logic                  err_r;
   logic                  unused_addr_lsbs;

   assign req = '{we:      req_we_i,
                  addr:    req_addr_i,
                  data:    req_data_i,
                  mask:    req_mask_i,
                  load_id: req_load_id_i};

   assign idx              = req.addr[2 +: idx_w_lp];
   assign in_range         = (req.addr[addr_width_p-1:2+idx_w_lp] == '0);
   assign unused_addr_lsbs = ^req.addr[1:0];

`ifdef BRG_XCEL_MEM_RESPONDER_STALL_EN
   logic [15:0] lfsr_r;

   // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         lfsr_r <= 16'hACE1;
      end else begin
         lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
      end
   end

   assign stall = (lfsr_r[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   assign req_ready_o = (inflight_r < max_out_lp) && !stall;
   assign accept      = req_v_i && req_ready_o;

   // Storage is not reset; stores commit on the accept edge so a load
   // accepted in the next cycle reads the updated word combinationally.
   always_ff @(posedge clk_i) begin
      if (accept && (req.we == e_mem_store) && in_range) begin
         for (int unsigned b = 0; b < mask_w_lp; b++) begin
            if (req.mask[b]) begin
               mem_r[idx][8*b +: 8] <= req.data[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      resp_in         = '0;
      resp_in.we      = req.we;
      resp_in.load_id = req.load_id;
      if ((req.we == e_mem_load) && in_range) begin
         resp_in.data = mem_r[idx];
      end
   end

   brg_xcel_mem_resp_pipe #(
      .latency_p (latency_p)
   ) resp_pipe (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (accept),
      .data_i    (resp_in),
      .v_o       (ret_v_o),
      .data_o    (resp_out)
   );

   assign ret_we_o      = resp_out.we;
   assign ret_data_o    = resp_out.data;
   assign ret_load_id_o = resp_out.load_id;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         inflight_r <= '0;
         err_r      <= 1'b0;
      end else begin
         case ({accept, ret_v_o})
            2'b10:   inflight_r <= inflight_r + 1'b1;
            2'b01:   inflight_r <= inflight_r - 1'b1;
            default: inflight_r <= inflight_r;
         endcase
         if (accept && !in_range) begin
            err_r <= 1'b1;
         end
      end
   end

   assign out_credits_o = max_out_lp - inflight_r;
   assign err_o         = err_r;

endmodule

// File: tb/tb_brg_xcel_mem_responder.sv
module tb_brg_xcel_mem_responder;

   localparam int LAT  = 2;
   localparam int MAXO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_v, req_we;
   logic [31:0] req_addr, req_data;
   logic [3:0]  req_mask;
   logic [10:0] req_id;
   logic        req_ready, ret_v, ret_we, err;
   logic [31:0] ret_data;
   logic [10:0] ret_id;
   logic [2:0]  credits;

   // second instance for the credit-limited configuration
   logic        v1;
   logic        ready1, ret_v1, ret_we1, err1;
   logic [31:0] ret_data1;
   logic [10:0] ret_id1;
   logic [1:0]  credits1;

   always #5 clk = ~clk;

   brg_xcel_mem_responder u0 (
      .clk_i(clk), .reset_n_i(rst_n),
      .req_v_i(req_v), .req_ready_o(req_ready), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_data_i(req_data), .req_mask_i(req_mask),
      .req_load_id_i(req_id),
      .ret_v_o(ret_v), .ret_we_o(ret_we), .ret_data_o(ret_data),
      .ret_load_id_o(ret_id), .out_credits_o(credits), .err_o(err));

   brg_xcel_mem_responder #(.latency_p(4), .max_out_p(2)) u1 (
      .clk_i(clk), .reset_n_i(rst_n),
      .req_v_i(v1), .req_ready_o(ready1), .req_we_i(1'b0),
      .req_addr_i(32'h0), .req_data_i(32'h0), .req_mask_i(4'h0),
      .req_load_id_i(11'h0),
      .ret_v_o(ret_v1), .ret_we_o(ret_we1), .ret_data_o(ret_data1),
      .ret_load_id_o(ret_id1), .out_credits_o(credits1), .err_o(err1));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic        we;
      logic [31:0] data;
      logic [10:0] id;
      int          due;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] data;
      logic [10:0] id;
      int          cyc;
   } rec_t;

   exp_t        mq[$];
   logic [31:0] mm [int];
   logic        m_err = 1'b0;
   logic [15:0] lfsr_m = 16'hACE1;
   bit          acc_flag = 1'b0;
   int          cyc = 0;
   int          ret_count = 0;
   rec_t        rlog[$];
   int          alog[$];

   always @(negedge clk) begin
      int   n;
      bit   due, m_ready, acc;
      exp_t e;
      cyc++;
      if (ret_v === 1'b1) begin
         rlog.push_back('{ret_we, ret_data, ret_id, cyc});
         ret_count++;
      end
      if (!rst_n) begin
         mq.delete();
         m_err    = 1'b0;
         lfsr_m   = 16'hACE1;
         acc_flag = 1'b0;
         chk("rst_ret_v", ret_v, 0);
         chk("rst_ret_we", ret_we, 0);
         chk("rst_ret_data", ret_data, 0);
         chk("rst_ret_id", ret_id, 0);
         chk("rst_credits", credits, MAXO);
         chk("rst_err", err, 0);
         chk("rst_ready", req_ready, 1);
      end else begin
         n       = mq.size();
         m_ready = (n < MAXO);
`ifdef BRG_XCEL_MEM_RESPONDER_STALL_EN
         if (lfsr_m[1:0] == 2'b00) m_ready = 1'b0;
`endif
         chk("ready", req_ready, m_ready);
         chk("credits", credits, MAXO - n);
         chk("err", err, m_err);
         due = (n > 0) && (mq[0].due == cyc);
         chk("ret_v", ret_v, due);
         if (due) begin
            chk("ret_we", ret_we, mq[0].we);
            chk("ret_data", ret_data, mq[0].data);
            chk("ret_id", ret_id, mq[0].id);
            void'(mq.pop_front());
         end
         acc      = req_v && m_ready;
         acc_flag = acc;
         if (acc) begin
            bit inr;
            int ix;
            alog.push_back(cyc);
            inr    = (req_addr[31:12] == 20'h0);
            ix     = int'(req_addr[11:2]);
            e.we   = req_we;
            e.id   = req_id;
            e.due  = cyc + LAT;
            e.data = 32'h0;
            if (!inr) m_err = 1'b1;
            if (!req_we && inr && mm.exists(ix)) e.data = mm[ix];
            if (req_we && inr) begin
               logic [31:0] w;
               w = mm.exists(ix) ? mm[ix] : 32'h0;
               for (int b = 0; b < 4; b++)
                  if (req_mask[b]) w[8*b +: 8] = req_data[8*b +: 8];
               mm[ix] = w;
            end
            mq.push_back(e);
         end
         lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic [10:0] id);
      req_v = 1'b1; req_we = we; req_addr = a; req_data = d; req_mask = m; req_id = id;
      for (int k = 0; k < 64; k++) begin
         @(posedge clk);
         if (acc_flag) begin
            #1;
            req_v = 1'b0;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL issue_timeout: got no accept expected accept within 64 cycles");
      #1;
      req_v = 1'b0;
   endtask

   int exp_c [8] = '{2, 1, 0, 0, 0, 1, 1, 0};
   int exp_r [8] = '{0, 0, 0, 0, 1, 1, 0, 0};

   initial begin
      int cnt_at_rst;
      rst_n = 1'b0; req_v = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
      req_mask = '0; req_id = '0; v1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

`ifndef BRG_XCEL_MEM_RESPONDER_STALL_EN
      // credit-limited instance: continuous loads
      v1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("u1_credits_c%0d", i), credits1, exp_c[i]);
         chk($sformatf("u1_ready_c%0d", i), ready1, exp_c[i] > 0);
         chk($sformatf("u1_ret_v_c%0d", i), ret_v1, exp_r[i]);
      end
      @(posedge clk);
      #1;
      v1 = 1'b0;
`endif
      wait_cyc(2);

      // store then back-to-back load of the same word
      rlog.delete(); alog.delete();
      issue(1'b1, 32'h10, 32'hCAFEBABE, 4'hF, 11'd3);
      issue(1'b0, 32'h10, 32'h0, 4'h0, 11'd7);
      wait_cyc(6);
      if (rlog.size() == 2 && alog.size() == 2) begin
         chk("st_ack_we", rlog[0].we, 1);
         chk("st_ack_id", rlog[0].id, 3);
         chk("st_ack_data", rlog[0].data, 0);
         chk("st_ack_lat", rlog[0].cyc - alog[0], 2);
         chk("ld_data", rlog[1].data, 32'hCAFEBABE);
         chk("ld_id", rlog[1].id, 7);
         chk("ld_we", rlog[1].we, 0);
         chk("ld_from_store", rlog[1].cyc - alog[0], 3);
      end else chk("resp_count_t2", rlog.size(), 2);

      // partial store
      rlog.delete(); alog.delete();
      issue(1'b1, 32'h10, 32'h000000EE, 4'b0001, 11'd1);
      issue(1'b0, 32'h13, 32'h0, 4'h0, 11'd2);
      wait_cyc(6);
      if (rlog.size() == 2) chk("partial_data", rlog[1].data, 32'hCAFEBAEE);
      else chk("resp_count_t3", rlog.size(), 2);

      // reset mid-burst drops in-flight responses, SRAM retained
      issue(1'b0, 32'h10, 32'h0, 4'h0, 11'd20);
      issue(1'b0, 32'h10, 32'h0, 4'h0, 11'd21);
      issue(1'b0, 32'h10, 32'h0, 4'h0, 11'd22);
      rst_n = 1'b0;
      cnt_at_rst = ret_count;
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(8);
      chk("no_ret_after_reset", ret_count, cnt_at_rst);
      rlog.delete(); alog.delete();
      issue(1'b0, 32'h10, 32'h0, 4'h0, 11'd30);
      wait_cyc(5);
      if (rlog.size() == 1) chk("retained_data", rlog[0].data, 32'hCAFEBAEE);
      else chk("resp_count_ret", rlog.size(), 1);

      // out of range
      rlog.delete(); alog.delete();
      chk("err_before_oor", err, 0);
      issue(1'b0, 32'h0001_0000, 32'h0, 4'h0, 11'd5);
      wait_cyc(5);
      chk("oor_err", err, 1);
      issue(1'b1, 32'h0001_0010, 32'h12345678, 4'hF, 11'd6);
      issue(1'b0, 32'h10, 32'h0, 4'h0, 11'd9);
      wait_cyc(6);
      chk("err_sticky", err, 1);
      if (rlog.size() == 3) begin
         chk("oor_ld_data", rlog[0].data, 0);
         chk("oor_ld_id", rlog[0].id, 5);
         chk("oor_st_ack", rlog[1].we, 1);
         chk("inrange_after_oor", rlog[2].data, 32'hCAFEBAEE);
      end else chk("resp_count_t5", rlog.size(), 3);

      // random traffic over a small pre-written pool
      for (int k = 0; k < 8; k++)
         issue(1'b1, 32'h100 + 32'(4 * k), $urandom, 4'hF, 11'(k));
      for (int k = 0; k < 400; k++) begin
         req_v    = ($urandom_range(3) != 0);
         req_we   = $urandom_range(1);
         req_addr = 32'h100 + 32'(4 * $urandom_range(7)) + 32'($urandom_range(3));
         if ($urandom_range(15) == 0) req_addr = req_addr | 32'h0002_0000;
         req_data = $urandom;
         req_mask = 4'($urandom);
         req_id   = 11'($urandom);
         wait_cyc(1);
      end
      req_v = 1'b0;
      wait_cyc(8);
      chk("drained", mq.size(), 0);
      chk("final_credits", credits, MAXO);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
